// File: rtl/tdc_readout_arbiter.sv
// tdc_readout_arbiter
//   Sequences one TDC acquisition/readout cycle. It clears the hit counters,
//   enables them until 'max' is reached, and then drains NCH channel FIFOs
//   onto one shared output bus. Channels are served round-robin, with at most
//   MAXBURST words per grant.
//
// Optional feature (macro TDC_ARB_CHTAG_EN):
//   When defined, adds o_out_ch, which carries the channel index of o_out_data.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   i_start       level: high runs a cycle, low aborts to IDLE
//   i_max         counters reached max (sampled only in ACQ)
//   o_cnt_clr     counter clear
//   o_cnt_ce      counter enable
//   i_fifo_empty  per-channel FIFO empty flags
//   o_fifo_rden   per-channel read strobe (one-hot or zero)
//   i_fifo_data   channel c data at [c*DW +: DW], valid 1 clk after rden
//   o_out_data    output word
//   o_out_valid   output word valid
//   i_out_ready   sink accepts the word on valid & ready
//   o_busy        high except in IDLE and DONE
//   o_done        all FIFOs drained after max
//   o_out_ch      channel tag of o_out_data (TDC_ARB_CHTAG_EN only)
//   o_word_cnt    words delivered this run, saturating
module tdc_readout_arbiter #(
  parameter int NCH      = 4,
  parameter int DW       = 32,
  parameter int MAXBURST = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_max,
  output logic              o_cnt_clr,
  output logic              o_cnt_ce,
  input  logic [NCH-1:0]    i_fifo_empty,
  output logic [NCH-1:0]    o_fifo_rden,
  input  logic [NCH*DW-1:0] i_fifo_data,
  output logic [DW-1:0]     o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done,
`ifdef TDC_ARB_CHTAG_EN
  output logic [$clog2(NCH)-1:0] o_out_ch,
`endif
  output logic [15:0]       o_word_cnt
);

  localparam int CHW = $clog2(NCH);
  localparam int BW  = $clog2(MAXBURST + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACQ, S_ARB, S_READ, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [CHW-1:0]  r_ptr;       // last granted channel; also the active grant in READ
  logic [BW-1:0]   r_burst;
  logic            r_pend;      // a read was issued last clk, data arrives now
  logic [DW-1:0]   r_out_data;
  logic            r_out_valid;
  logic [15:0]     r_word_cnt;
  logic            w_found;
  logic [CHW-1:0]  w_sel;
  logic [CHW-1:0]  w_idx;
  logic            w_rd_ok;
  logic [DW-1:0]   w_word;
`ifdef TDC_ARB_CHTAG_EN
  logic [CHW-1:0]  r_out_ch;
`endif

  // Round-robin search starting after the last grant; the last granted
  // channel is checked last so others get a turn first.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = CHW'((int'(r_ptr) + i) % NCH);
      if (!w_found && !i_fifo_empty[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // The read strobe is gated on i_start combinationally so an abort stops
  // reads in the same clock.
  assign w_rd_ok = (r_state == S_READ) && i_start && !r_pend &&
                   !i_fifo_empty[r_ptr] && (!r_out_valid || i_out_ready) &&
                   (r_burst < BW'(MAXBURST));
  assign o_fifo_rden = w_rd_ok ? (NCH'(1) << r_ptr) : '0;
  assign w_word      = i_fifo_data[int'(r_ptr)*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_ACQ;
      S_ACQ:   if (i_max) w_next = S_ARB;
      // DONE only once the last word has left the output register.
      S_ARB: begin
        if (w_found)           w_next = S_READ;
        else if (!r_out_valid) w_next = S_DONE;
      end
      S_READ:  if (!r_pend && (i_fifo_empty[r_ptr] || r_burst == BW'(MAXBURST)))
                 w_next = S_ARB;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (!i_start) w_next = S_IDLE;
  end

  assign o_cnt_clr = (r_state == S_IDLE) || (r_state == S_CLEAR);
  assign o_cnt_ce  = (r_state == S_ACQ);
  assign o_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done    = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= CHW'(NCH - 1);
      r_burst     <= '0;
      r_pend      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_word_cnt  <= '0;
`ifdef TDC_ARB_CHTAG_EN
      r_out_ch    <= '0;
`endif
    end else begin
      if (r_out_valid && i_out_ready && r_word_cnt != 16'hFFFF)
        r_word_cnt <= r_word_cnt + 16'd1;
      if (r_state == S_CLEAR)
        r_word_cnt <= '0;

      if (!i_start) begin
        // Abort: any word in flight is dropped.
        r_pend      <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        if (r_pend) begin
          r_out_data  <= w_word;
          r_out_valid <= 1'b1;
          r_pend      <= 1'b0;
`ifdef TDC_ARB_CHTAG_EN
          r_out_ch    <= r_ptr;
`endif
        end else if (r_out_valid && i_out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (w_rd_ok) begin
          r_pend  <= 1'b1;
          r_burst <= r_burst + BW'(1);
        end
        if (r_state == S_ARB && w_found) begin
          r_ptr   <= w_sel;
          r_burst <= '0;
        end
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_word_cnt  = r_word_cnt;
`ifdef TDC_ARB_CHTAG_EN
  assign o_out_ch    = r_out_ch;
`endif

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
module tb_tdc_readout_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int MB  = 3;
  localparam int DEP = 64;

  logic              clk;
  logic              rst_n;
  logic              i_start;
  logic              i_max;
  logic              o_cnt_clr;
  logic              o_cnt_ce;
  logic [NCH-1:0]    fifo_empty;
  logic [NCH-1:0]    o_fifo_rden;
  logic [NCH*DW-1:0] fifo_data;
  logic [DW-1:0]     o_out_data;
  logic              o_out_valid;
  logic              i_out_ready;
  logic              o_busy;
  logic              o_done;
  logic [15:0]       o_word_cnt;
`ifdef TDC_ARB_CHTAG_EN
  logic [1:0]        o_out_ch;
`endif

  tdc_readout_arbiter #(.NCH(NCH), .DW(DW), .MAXBURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_max(i_max),
    .o_cnt_clr(o_cnt_clr), .o_cnt_ce(o_cnt_ce),
    .i_fifo_empty(fifo_empty), .o_fifo_rden(o_fifo_rden), .i_fifo_data(fifo_data),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_busy(o_busy), .o_done(o_done),
`ifdef TDC_ARB_CHTAG_EN
    .o_out_ch(o_out_ch),
`endif
    .o_word_cnt(o_word_cnt)
  );

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural channel FIFOs: circular storage, write count owned by the
  // stimulus, read count owned by the read process.
  logic [DW-1:0] mem [NCH][DEP];
  int nw [NCH];
  int nr [NCH];
  int lastpop;
  int seq;
  logic stall;

  for (genvar c = 0; c < NCH; c++) begin : g_empty
    assign fifo_empty[c] = (nw[c] == nr[c]);
  end

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (o_fifo_rden[c]) begin
        fifo_data[c*DW +: DW] <= mem[c][nr[c] % DEP];
        nr[c]   <= nr[c] + 1;
        lastpop <= c;
      end
    end
  end

  initial begin
    i_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  logic [DW-1:0] exp_q[$];
  int m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: checks read-strobe rules, output hold and word order.
  initial begin
    logic          hold_pend;
    logic [DW-1:0] hold_data;
    logic [DW-1:0] e;
    hold_pend = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_out_valid && hold_pend)
          chk("hold_data", o_out_data, hold_data);
        if (o_fifo_rden != '0)
          chk("rden_rule", {31'd0, $onehot(o_fifo_rden) && ((o_fifo_rden & fifo_empty) == '0)
                           && (!o_out_valid || i_out_ready)}, 32'd1);
        if (o_out_valid && i_out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", o_out_data, 32'hDEAD_0000);
          end else begin
            e = exp_q.pop_front();
            chk("word", o_out_data, e);
`ifdef TDC_ARB_CHTAG_EN
            chk("word_ch", {30'd0, o_out_ch}, {24'd0, e[31:24]});
`endif
          end
        end
        hold_pend = o_out_valid && !i_out_ready;
        hold_data = o_out_data;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int plan [NCH];

  task automatic load_plan();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < plan[c]; k++) begin
        mem[c][nw[c] % DEP] = {8'(c), 24'(seq)};
        seq++;
        nw[c] = nw[c] + 1;
      end
    end
  endtask

  // Reference readout order: repeatedly take the next non-empty channel after
  // the previous grant and remove up to MB words from it.
  task automatic build_exp(output int ntot);
    int rem [NCH];
    int rp  [NCH];
    int g;
    int n;
    ntot = 0;
    for (int c = 0; c < NCH; c++) begin
      rem[c] = nw[c] - nr[c];
      rp[c]  = nr[c];
    end
    forever begin
      g = -1;
      for (int i = 1; i <= NCH; i++)
        if (g < 0 && rem[(m_ptr + i) % NCH] > 0) g = (m_ptr + i) % NCH;
      if (g < 0) break;
      n = (rem[g] < MB) ? rem[g] : MB;
      for (int k = 0; k < n; k++) exp_q.push_back(mem[g][(rp[g] + k) % DEP]);
      rp[g]  += n;
      rem[g] -= n;
      ntot   += n;
      m_ptr   = g;
    end
  endtask

  task automatic start_to_max(output int ntot);
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    load_plan();
    build_exp(ntot);
    i_max = 1'b1;
    @(negedge clk);
    i_max = 1'b0;
  endtask

  task automatic do_run(input bit stall_test);
    int ntot;
    int k;
    start_to_max(ntot);
    if (stall_test) begin
      k = 0;
      while (!o_out_valid && k < 200) begin @(negedge clk); k++; end
      chk("stall_first_valid", {31'd0, o_out_valid}, 32'd1);
      stall = 1'b1;
      repeat (21) @(negedge clk);
      chk("stall_valid_held", {31'd0, o_out_valid}, 32'd1);
      stall = 1'b0;
    end
    k = 0;
    while (!o_done && k < 3000) begin @(negedge clk); k++; end
    chk("done", {31'd0, o_done}, 32'd1);
    chk("word_cnt", {16'd0, o_word_cnt}, ntot);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    i_start = 1'b0;
    @(negedge clk);
    chk("idle_clr", {31'd0, o_cnt_clr}, 32'd1);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic abort_run(input bit use_reset);
    int ntot;
    int k;
    for (int c = 0; c < NCH; c++) plan[c] = 4;
    start_to_max(ntot);
    k = 0;
    while (o_fifo_rden == '0 && k < 200) begin @(negedge clk); k++; end
    chk("abort_saw_rden", {31'd0, (o_fifo_rden != '0)}, 32'd1);
    @(negedge clk);  // read issued, word in flight
    if (use_reset) begin
      #2;
      rst_n   = 1'b0;
      i_start = 1'b0;
      #1;
      chk("rst_clr",   {31'd0, o_cnt_clr},   32'd1);
      chk("rst_ce",    {31'd0, o_cnt_ce},    32'd0);
      chk("rst_rden",  {28'd0, o_fifo_rden}, 32'd0);
      chk("rst_valid", {31'd0, o_out_valid}, 32'd0);
      chk("rst_busy",  {31'd0, o_busy},      32'd0);
      chk("rst_done",  {31'd0, o_done},      32'd0);
      chk("rst_wcnt",  {16'd0, o_word_cnt},  32'd0);
      chk("rst_data",  o_out_data,           32'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      m_ptr = NCH - 1;
    end else begin
      i_start = 1'b0;
      #1;
      chk("abort_rden", {28'd0, o_fifo_rden}, 32'd0);
      @(negedge clk);
      chk("abort_valid", {31'd0, o_out_valid}, 32'd0);
      chk("abort_busy",  {31'd0, o_busy},      32'd0);
      chk("abort_clr",   {31'd0, o_cnt_clr},   32'd1);
      m_ptr = lastpop;
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int n;
    stall   = 1'b0;
    seq     = 0;
    m_ptr   = NCH - 1;
    lastpop = 0;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_max   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_clr",   {31'd0, o_cnt_clr},   32'd1);
    chk("reset_valid", {31'd0, o_out_valid}, 32'd0);
    chk("reset_done",  {31'd0, o_done},      32'd0);
    rst_n = 1'b1;

    // Empty FIFOs: 2 clk of clear, 10 clk of enable, done 2 clk after max.
    @(negedge clk);
    i_start = 1'b1;
    chk("t2_clr_idle", {31'd0, o_cnt_clr}, 32'd1);
    @(negedge clk);
    chk("t2_clr_clear", {31'd0, o_cnt_clr}, 32'd1);
    chk("t2_ce_clear",  {31'd0, o_cnt_ce},  32'd0);
    chk("t2_busy",      {31'd0, o_busy},    32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_cnt_ce && !o_cnt_clr) n++;
    end
    chk("t2_ce_cycles", n, 32'd10);
    i_max = 1'b1;
    @(negedge clk);
    i_max = 1'b0;
    chk("t2_ce_off", {31'd0, o_cnt_ce}, 32'd0);
    chk("t2_done_early", {31'd0, o_done}, 32'd0);
    @(negedge clk);
    chk("t2_done", {31'd0, o_done}, 32'd1);
    i_start = 1'b0;
    @(negedge clk);
    chk("t2_idle_done", {31'd0, o_done}, 32'd0);

    // ch0 x3, ch2 x2
    plan = '{3, 0, 2, 0};
    do_run(1'b0);

    // Burst limit with uneven channels
    plan = '{0, 5, 0, 1};
    do_run(1'b0);

    // Output stall for 20 clk
    plan = '{4, 2, 3, 1};
    do_run(1'b1);

    abort_run(1'b0);
    plan = '{0, 0, 0, 0};
    do_run(1'b0);

    abort_run(1'b1);
    plan = '{1, 0, 0, 2};
    do_run(1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < NCH; c++) plan[c] = $urandom_range(0, 7);
      do_run(r == 5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
